ex_mem: RTL and testbench



---
 rtl/ex_mem.sv | 106 ++++++++++
 tb/tb_ex_mem.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem.sv
// EX/MEM pipeline register with stall/bubble/flush handling.
// Also holds two-cycle multiply-accumulate state for EX.
module ex_mem #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int STALL_W = 6,
  parameter int EX_IDX  = 3,
  parameter int MEM_IDX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   ex_wd,
  input  logic                ex_wreg,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic                ex_whilo,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic [2*DATA_W-1:0] hilo_temp_i,
  input  logic [1:0]          cnt_i,
  output logic [ADDR_W-1:0]   mem_wd,
  output logic                mem_wreg,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_whilo,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic [2*DATA_W-1:0] hilo_temp_o,
  output logic [1:0]          cnt_o
);

  typedef struct packed {
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
    logic              whilo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } mem_t;

  mem_t                out_q, out_d, ex_in;
  logic [2*DATA_W-1:0] temp_q, temp_d;
  logic [1:0]          cnt_q, cnt_d;
  logic                ex_st, mem_st;
  logic                unused_stall;

  assign ex_st  = stall[EX_IDX];
  assign mem_st = stall[MEM_IDX];
  assign unused_stall = ^stall;

  assign ex_in = '{
    wd:    ex_wd,
    wreg:  ex_wreg,
    wdata: ex_wdata,
    whilo: ex_whilo,
    hi:    ex_hi,
    lo:    ex_lo
  };

  always_comb begin
    out_d  = out_q;
    temp_d = temp_q;
    cnt_d  = cnt_q;
    unique case (1'b1)
      flush: begin
        out_d  = '0;
        temp_d = '0;
        cnt_d  = '0;
      end
      // EX stalled, MEM free: bubble, keep EX's partial result
      (!flush && ex_st && !mem_st): begin
        out_d  = '0;
        temp_d = hilo_temp_i;
        cnt_d  = cnt_i;
      end
      (!flush && !ex_st): begin
        out_d  = ex_in;
        temp_d = '0;
        cnt_d  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      temp_q <= '0;
      cnt_q  <= '0;
    end else begin
      out_q  <= out_d;
      temp_q <= temp_d;
      cnt_q  <= cnt_d;
    end
  end

  assign mem_wd      = out_q.wd;
  assign mem_wreg    = out_q.wreg;
  assign mem_wdata   = out_q.wdata;
  assign mem_whilo   = out_q.whilo;
  assign mem_hi      = out_q.hi;
  assign mem_lo      = out_q.lo;
  assign hilo_temp_o = temp_q;
  assign cnt_o       = cnt_q;

endmodule

// File: tb/tb_ex_mem.sv
// Table-driven scoreboard bench for ex_mem.
// Expected outputs come from hand-derived vector rows.
module tb_ex_mem;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic        ex_whilo;
  logic [31:0] ex_hi;
  logic [31:0] ex_lo;
  logic [63:0] hilo_temp_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic [63:0] hilo_temp_o;
  logic [1:0]  cnt_o;

  ex_mem dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .hilo_temp_i(hilo_temp_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .hilo_temp_o(hilo_temp_o), .cnt_o(cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] temp;
    logic [1:0]  cnt;
  } out_t;

  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] temp;
    logic [1:0]  cnt;
    out_t        exp;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  out_t sb[$];
  vec_t tbl[$];
  out_t zero_o;

  function automatic out_t o(
    input logic [4:0] wd, input logic wreg,
    input logic [31:0] wdata, input logic whilo,
    input logic [31:0] hi, input logic [31:0] lo,
    input logic [63:0] temp, input logic [1:0] cnt);
    out_t r;
    r = '{wd, wreg, wdata, whilo, hi, lo, temp, cnt};
    return r;
  endfunction

  function automatic vec_t mk(
    input logic [5:0] st, input logic fl,
    input logic [4:0] wd, input logic wreg,
    input logic [31:0] wdata, input logic whilo,
    input logic [31:0] hi, input logic [31:0] lo,
    input logic [63:0] temp, input logic [1:0] cnt,
    input out_t e);
    vec_t v;
    v = '{st, fl, wd, wreg, wdata, whilo, hi, lo, temp, cnt, e};
    return v;
  endfunction

  function automatic out_t dut_out();
    return o(mem_wd, mem_wreg, mem_wdata, mem_whilo,
             mem_hi, mem_lo, hilo_temp_o, cnt_o);
  endfunction

  task automatic drive(input vec_t v);
    assert (!(!v.stall[3] && v.stall[4]))
      else $error("illegal stall pattern %b", v.stall);
    stall       = v.stall;
    flush       = v.flush;
    ex_wd       = v.wd;
    ex_wreg     = v.wreg;
    ex_wdata    = v.wdata;
    ex_whilo    = v.whilo;
    ex_hi       = v.hi;
    ex_lo       = v.lo;
    hilo_temp_i = v.temp;
    cnt_i       = v.cnt;
    sb.push_back(v.exp);
  endtask

  task automatic check(input string name, input int idx);
    out_t e, a;
    checks++;
    a = dut_out();
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s[%0d]: scoreboard empty, got %h", name, idx, a);
    end else begin
      e = sb.pop_front();
      if (a !== e) begin
        errors++;
        $display("FAIL %s[%0d]: got %h want %h", name, idx, a, e);
      end
    end
  endtask

  initial begin
    zero_o = o(0, 0, 0, 0, 0, 0, 0, 0);

    tbl.push_back(mk(6'b000000, 0, 3, 1, 32'h1234_5678, 1,
      32'hAAAA_0000, 32'h0000_5555, 64'hFFFF, 2'd3,
      o(3, 1, 32'h1234_5678, 1, 32'hAAAA_0000, 32'h0000_5555, 0, 0)));
    tbl.push_back(mk(6'b001111, 0, 7, 1, 32'h1111_1111, 1, 2, 3,
      64'h0000_0001_FFFF_FFFE, 2'b01,
      o(0, 0, 0, 0, 0, 0, 64'h0000_0001_FFFF_FFFE, 2'b01)));
    tbl.push_back(mk(6'b000000, 0, 9, 1, 32'h2222_2222, 0, 4, 5,
      64'h55, 2'd2, o(9, 1, 32'h2222_2222, 0, 4, 5, 0, 0)));
    tbl.push_back(mk(6'b000000, 0, 31, 1, 32'hDEAD_BEEF, 1,
      32'hCAFE, 32'hF00D, 0, 0,
      o(31, 1, 32'hDEAD_BEEF, 1, 32'hCAFE, 32'hF00D, 0, 0)));
    for (int i = 1; i <= 3; i++)
      tbl.push_back(mk(6'b011111, 0, 5'(i), 1, 32'(i), 0,
        32'(i), 32'(i), 64'(i), 2'(i),
        o(31, 1, 32'hDEAD_BEEF, 1, 32'hCAFE, 32'hF00D, 0, 0)));
    tbl.push_back(mk(6'b001111, 0, 4, 1, 32'h3333_3333, 1, 6, 7,
      64'h1234, 2'd1, o(0, 0, 0, 0, 0, 0, 64'h1234, 2'd1)));
    tbl.push_back(mk(6'b111111, 0, 5, 1, 32'h4444_4444, 1, 8, 9,
      64'h9999, 2'd2, o(0, 0, 0, 0, 0, 0, 64'h1234, 2'd1)));
    tbl.push_back(mk(6'b000111, 0, 6, 1, 32'h5555_5555, 1, 10, 11,
      64'h8888, 2'd3, o(6, 1, 32'h5555_5555, 1, 10, 11, 0, 0)));
    tbl.push_back(mk(6'b001111, 0, 2, 1, 1, 1, 1, 1,
      64'hABCD, 2'd2, o(0, 0, 0, 0, 0, 0, 64'hABCD, 2'd2)));
    tbl.push_back(mk(6'b011111, 1, 8, 1, 32'h6666_6666, 1, 12, 13,
      64'h4321, 2'd3, zero_o));
    tbl.push_back(mk(6'b000000, 0, 10, 1, 32'h7777_7777, 1, 14, 15,
      0, 0, o(10, 1, 32'h7777_7777, 1, 14, 15, 0, 0)));
    tbl.push_back(mk(6'b001111, 1, 11, 1, 32'h8888_8888, 1, 16, 17,
      64'h0000_0001_FFFF_FFFE, 2'b01, zero_o));
    for (int i = 1; i <= 5; i++)
      tbl.push_back(mk(6'b000000, 0, 5'(i), 1, 32'(i), 0, 0, 0, 0, 0,
        o(5'(i), 1, 32'(i), 0, 0, 0, 0, 0)));

    // async reset with busy inputs
    rst = 1'b0;
    drive(mk(6'b000000, 0, 5'h1F, 1, 32'hFFFF_FFFF, 1,
      32'hFFFF_FFFF, 32'hFFFF_FFFF, '1, 2'd3, zero_o));
    #2 rst = 1'b1;
    #1 check("reset_async", 0);
    sb.push_back(zero_o);
    @(posedge clk); #1 check("reset_hold", 0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(posedge clk); #1 check("vec", i);
      @(negedge clk);
    end

    // reset during a multi-cycle op clears the EX side state
    drive(mk(6'b001111, 0, 3, 1, 32'h99, 1, 1, 2,
      64'hFEED_0000_0000_BEEF, 2'b01,
      o(0, 0, 0, 0, 0, 0, 64'hFEED_0000_0000_BEEF, 2'b01)));
    @(posedge clk); #1 check("mid_op_capture", 0);
    drive(mk(6'b000000, 0, 4, 1, 32'hAB, 1, 3, 4, 64'h77, 2'd2,
      zero_o));
    @(negedge clk);
    rst = 1'b1;
    #1 check("mid_op_reset", 0);
    sb.push_back(zero_o);
    @(posedge clk); #1 check("mid_op_reset_hold", 0);
    @(negedge clk) rst = 1'b0;
    drive(mk(6'b000000, 0, 4, 1, 32'hAB, 1, 3, 4, 64'h77, 2'd2,
      o(4, 1, 32'hAB, 1, 3, 4, 0, 0)));
    @(posedge clk); #1 check("post_reset_adv", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
